// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding select, load-use stall and flush-bubble control.
// Optional hazard counters are enabled with `define HAZARD_STATS_EN.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic              stall,
  output logic              ex_bubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_count,
  output logic [31:0]       fwd_mem_count,
  output logic [31:0]       fwd_wb_count
`endif
);

  localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(2);

  // Interface contract: there is no valid/ready pair here. id_valid qualifies
  // the ID fields; stall is the back-pressure, and an ID instruction is taken
  // into EX only on an edge where id_valid && !stall && !flush.

  // A WB-stage record is not kept: the 01 code is decided from the MEM record
  // on the edge where it moves into WB, so nothing reads WB metadata later.
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_reg_write;

  logic              accept;
  logic [SEL_W-1:0]  sel_a_next;
  logic [SEL_W-1:0]  sel_b_next;

  always_comb begin
    stall = id_valid && ex_mem_read && (ex_rd != '0) &&
            ((id_use_rs1 && (id_rs1 == ex_rd)) ||
             (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  assign accept = id_valid && !flush && !stall;

  // Nearest producer first: the instruction now in EX will be in MEM next cycle.
  always_comb begin
    sel_a_next = SEL_RF;
    sel_b_next = SEL_RF;
    if (accept) begin
      if (id_use_rs1 && ex_reg_write && (ex_rd != '0) && (ex_rd == id_rs1))
        sel_a_next = SEL_MEM;
      else if (id_use_rs1 && mem_reg_write && (mem_rd != '0) && (mem_rd == id_rs1))
        sel_a_next = SEL_WB;
      if (id_use_rs2 && ex_reg_write && (ex_rd != '0) && (ex_rd == id_rs2))
        sel_b_next = SEL_MEM;
      else if (id_use_rs2 && mem_reg_write && (mem_rd != '0) && (mem_rd == id_rs2))
        sel_b_next = SEL_WB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      mem_rd        <= '0;
      mem_reg_write <= 1'b0;
      fwd_a_sel     <= SEL_RF;
      fwd_b_sel     <= SEL_RF;
      ex_bubble     <= 1'b1;
    end else begin
      mem_rd        <= ex_rd;
      mem_reg_write <= ex_reg_write;
      ex_rd         <= accept ? id_rd : '0;
      ex_reg_write  <= accept && id_reg_write;
      ex_mem_read   <= accept && id_mem_read;
      fwd_a_sel     <= sel_a_next;
      fwd_b_sel     <= sel_b_next;
      ex_bubble     <= !accept;
    end
  end

`ifdef HAZARD_STATS_EN
  // Counters update on the same edge as the selects they count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count   <= '0;
      fwd_mem_count <= '0;
      fwd_wb_count  <= '0;
    end else begin
      stall_count   <= stall_count + 32'(stall);
      fwd_mem_count <= fwd_mem_count + 32'(sel_a_next == SEL_MEM) + 32'(sel_b_next == SEL_MEM);
      fwd_wb_count  <= fwd_wb_count + 32'(sel_a_next == SEL_WB) + 32'(sel_b_next == SEL_WB);
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: pipeline-slot model compared every cycle,
// plus literal expectations for each hazard scenario.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall, ex_bubble;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count, fwd_mem_count, fwd_wb_count;
`endif

  fwd_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .ex_bubble(ex_bubble)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count), .fwd_mem_count(fwd_mem_count), .fwd_wb_count(fwd_wb_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: slot 0 = EX, slot 1 = MEM, slot 2 = WB (history of what entered EX)
  logic [4:0]  m_rd[3];
  logic        m_rw[3];
  logic        m_mr[3];
  logic [1:0]  m_a = '0, m_b = '0;
  logic        m_bub = 1'b1;
  logic        model_ok = 1'b0;
  logic [31:0] m_stall_cnt = '0, m_mem_cnt = '0, m_wb_cnt = '0;

  function automatic logic model_stall();
    if (!id_valid || !m_mr[0] || m_rd[0] == 5'd0) return 1'b0;
    return (id_use_rs1 && id_rs1 == m_rd[0]) || (id_use_rs2 && id_rs2 == m_rd[0]);
  endfunction

  // Scan producers nearest first; slot 0 maps to the MEM code, slot 1 to WB.
  function automatic logic [1:0] model_sel(input logic [4:0] rs, input logic use_rs);
    if (!use_rs || rs == 5'd0) return 2'b00;
    for (int s = 0; s < 2; s++)
      if (m_rw[s] && m_rd[s] == rs) return (s == 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    logic st, acc;
    if (rst) begin
      for (int s = 0; s < 3; s++) begin
        m_rd[s] = '0; m_rw[s] = 1'b0; m_mr[s] = 1'b0;
      end
      m_a = '0; m_b = '0; m_bub = 1'b1;
      m_stall_cnt = '0; m_mem_cnt = '0; m_wb_cnt = '0;
    end else begin
      st  = model_stall();
      acc = id_valid && !flush && !st;
      m_a = acc ? model_sel(id_rs1, id_use_rs1) : 2'b00;
      m_b = acc ? model_sel(id_rs2, id_use_rs2) : 2'b00;
      m_bub = !acc;
      m_stall_cnt += 32'(st);
      m_mem_cnt += 32'(m_a == 2'b10) + 32'(m_b == 2'b10);
      m_wb_cnt  += 32'(m_a == 2'b01) + 32'(m_b == 2'b01);
      for (int s = 2; s > 0; s--) begin
        m_rd[s] = m_rd[s-1]; m_rw[s] = m_rw[s-1]; m_mr[s] = m_mr[s-1];
      end
      m_rd[0] = acc ? id_rd : 5'd0;
      m_rw[0] = acc && id_reg_write;
      m_mr[0] = acc && id_mem_read;
    end
    model_ok = 1'b1;
  end

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (model_ok) begin
      cmp("model_stall", 32'(stall), 32'(model_stall()));
      cmp("model_fwd_a", 32'(fwd_a_sel), 32'(m_a));
      cmp("model_fwd_b", 32'(fwd_b_sel), 32'(m_b));
      cmp("model_ex_bubble", 32'(ex_bubble), 32'(m_bub));
`ifdef HAZARD_STATS_EN
      cmp("model_stall_count", stall_count, m_stall_cnt);
      cmp("model_fwd_mem_count", fwd_mem_count, m_mem_cnt);
      cmp("model_fwd_wb_count", fwd_wb_count, m_wb_cnt);
`endif
    end
  end

  // driver tasks: apply one ID vector after the edge, return at the next negedge
  task automatic drive(input logic v, input logic [4:0] rd, rs1, rs2,
                       input logic u1, u2, rw, mr, fl, r);
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; id_reg_write = rw; id_mem_read = mr; flush = fl;
    @(negedge clk);
  endtask

  task automatic alu(input logic [4:0] rd, rs1, rs2);
    drive(1'b1, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic addi(input logic [4:0] rd, rs1);
    drive(1'b1, rd, rs1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic lw(input logic [4:0] rd, rs1);
    drive(1'b1, rd, rs1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input string name, input logic [1:0] a, b, input logic bub);
    cmp({name, "_a"}, 32'(fwd_a_sel), 32'(a));
    cmp({name, "_b"}, 32'(fwd_b_sel), 32'(b));
    cmp({name, "_bubble"}, 32'(ex_bubble), 32'(bub));
  endtask

  initial begin
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("reset", 2'b00, 2'b00, 1'b1);
    cmp("reset_stall", 32'(stall), 32'd0);
    nop();

    // back-to-back ALU
    alu(5, 1, 2);
    alu(6, 5, 7);
    cmp("b2b_stall", 32'(stall), 32'd0);
    nop();
    expect_out("b2b", 2'b10, 2'b00, 1'b0);

    // distance 2
    alu(5, 1, 2);
    nop();
    alu(8, 5, 5);
    nop();
    expect_out("dist2", 2'b01, 2'b01, 1'b0);

    // double producer, nearest wins
    alu(5, 1, 2);
    addi(5, 5);
    alu(11, 5, 3);
    nop();
    expect_out("nearest", 2'b10, 2'b00, 1'b0);

    // load-use: one stall cycle, then forward from WB
    lw(9, 2);
    alu(10, 9, 1);
    cmp("lu_stall_on", 32'(stall), 32'd1);
    alu(10, 9, 1);
    cmp("lu_stall_off", 32'(stall), 32'd0);
    expect_out("lu_bubble", 2'b00, 2'b00, 1'b1);
    nop();
    expect_out("lu_consumer", 2'b01, 2'b00, 1'b0);

    // x0 never forwards
    alu(0, 1, 2);
    alu(12, 0, 0);
    nop();
    expect_out("x0", 2'b00, 2'b00, 1'b0);

    // reset with a load in EX and its consumer in ID
    lw(9, 2);
    drive(1'b1, 5'd10, 5'd9, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    alu(10, 9, 1);
    cmp("rst_mid_stall", 32'(stall), 32'd0);
    expect_out("rst_mid", 2'b00, 2'b00, 1'b1);
    nop();
    expect_out("rst_after", 2'b00, 2'b00, 1'b0);

    // flush kills a dependent instruction
    alu(5, 1, 2);
    drive(1'b1, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    nop();
    expect_out("flush", 2'b00, 2'b00, 1'b1);

    // flush and stall together
    lw(9, 2);
    drive(1'b1, 5'd10, 5'd9, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cmp("flush_stall_stall", 32'(stall), 32'd1);
    nop();
    expect_out("flush_stall", 2'b00, 2'b00, 1'b1);
    cmp("flush_stall_after", 32'(stall), 32'd0);

    // three load-use pairs from reset
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      lw(5'(20 + k), 3);
      alu(5'(25 + k), 5'(20 + k), 4);
      alu(5'(25 + k), 5'(20 + k), 4);
    end
    nop();
    nop();
`ifdef HAZARD_STATS_EN
    cmp("stats_stall_count", stall_count, 32'd3);
    cmp("stats_fwd_wb_count", fwd_wb_count, 32'd3);
    cmp("stats_fwd_mem_count", fwd_mem_count, 32'd0);
`endif
    expect_out("tail", 2'b00, 2'b00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
